// File: rtl/score_event_gen.sv
// Tic-tac-toe round evaluator: after each move it looks for completed lines and
// sends one fixed-width increment pulse to the winning side's score counter.
module score_event_gen #(
  parameter int PULSE_LEN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] board,
  input  logic        move_done,
  input  logic        new_game,
  output logic        inc_x,
  output logic        inc_o,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [7:0]  win_line
);

  typedef enum logic [1:0] {IDLE, EVAL, PULSE, OVER} state_t;

  localparam logic [3:0] LAST = 4'(PULSE_LEN - 1);

  state_t      state;
  logic [17:0] board_p0;
  logic [3:0]  cnt;
  logic [7:0]  x_lines;
  logic [7:0]  o_lines;
  logic        full;

  function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] who);
    logic [8:0] own;
    logic [7:0] l;
    for (int i = 0; i < 9; i++) own[i] = (b[2*i +: 2] == who);
    l[0] = own[0] & own[1] & own[2];
    l[1] = own[3] & own[4] & own[5];
    l[2] = own[6] & own[7] & own[8];
    l[3] = own[0] & own[3] & own[6];
    l[4] = own[1] & own[4] & own[7];
    l[5] = own[2] & own[5] & own[8];
    l[6] = own[0] & own[4] & own[8];
    l[7] = own[2] & own[4] & own[6];
    return l;
  endfunction

  // Code 11 counts as empty, so a cell is occupied only when it holds exactly X or O.
  function automatic logic board_full(input logic [17:0] b);
    logic f;
    f = 1'b1;
    for (int i = 0; i < 9; i++)
      if (b[2*i +: 2] != 2'b01 && b[2*i +: 2] != 2'b10) f = 1'b0;
    return f;
  endfunction

  always_comb begin
    x_lines = lines_of(board_p0, 2'b01);
    o_lines = lines_of(board_p0, 2'b10);
    full    = board_full(board_p0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      board_p0  <= '0;
      cnt       <= '0;
      inc_x     <= 1'b0;
      inc_o     <= 1'b0;
      game_over <= 1'b0;
      winner    <= 2'b00;
      win_line  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (move_done) begin
            board_p0 <= board;
            state    <= EVAL;
          end
        end
        EVAL: begin
          if ((|x_lines) && (|o_lines)) begin
            winner    <= 2'b11;
            win_line  <= '0;
            game_over <= 1'b1;
            state     <= OVER;
          end else if (|x_lines) begin
            winner   <= 2'b01;
            win_line <= x_lines;
            inc_x    <= 1'b1;
            cnt      <= '0;
            state    <= PULSE;
          end else if (|o_lines) begin
            winner   <= 2'b10;
            win_line <= o_lines;
            inc_o    <= 1'b1;
            cnt      <= '0;
            state    <= PULSE;
          end else if (full) begin
            winner    <= 2'b00;
            win_line  <= '0;
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            state <= IDLE;
          end
        end
        // cnt tops out at PULSE_LEN-1 (<= 14), so it can never wrap.
        PULSE: begin
          if (cnt == LAST) begin
            inc_x     <= 1'b0;
            inc_o     <= 1'b0;
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        OVER: begin
          if (new_game) begin
            winner    <= 2'b00;
            win_line  <= '0;
            game_over <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
